// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with sequential advance, branch/jump redirect and timed IF/ID flush.
// Optional: define PC_MISALIGN_TRAP_EN to vector misaligned redirect targets to TRAP_VEC and pulse misalign_trap.
module pc_sequencer #(
    parameter int unsigned     PC_W         = 10,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] TRAP_VEC     = 10'h3F0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      jump,
    input  logic            jump_valid,
    input  logic [31:0]     jump_result,
    input  logic            stall,
    input  logic            imem_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            flush,
    output logic [15:0]     redirect_cnt,
    output logic            misalign_trap
);

    localparam int unsigned BUB_W    = 3;
    localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             flush_q, flush_d;
    logic             trap_q, trap_d;

    logic             redirect_req;
    logic [PC_W-1:0]  target;
    logic             trap_hit;
    logic             unused_bits;

    assign redirect_req = jump_valid && (jump != 2'b00);

    // Upper target bits beyond the PC width are architecturally ignored.
    assign unused_bits = ^{jump_result[31:PC_W], jump_result[1:0], TRAP_VEC};

    always_comb begin
        target   = {jump_result[PC_W-1:2], 2'b00};
        trap_hit = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (jump_result[1:0] != 2'b00) begin
            target   = TRAP_VEC;
            trap_hit = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bub_d   = bub_q;
        cnt_d   = cnt_q;
        trap_d  = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_FLUSH: begin
                if (redirect_req) begin
                    state_d = S_FLUSH;
                    pc_d    = target;
                    bub_d   = BUB_LOAD;
                    trap_d  = trap_hit;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (state_q == S_FLUSH) begin
                    // Leaving on the count of 1 gives exactly FLUSH_CYCLES flush cycles.
                    if (bub_q <= BUB_W'(1)) begin
                        state_d = S_RUN;
                        bub_d   = '0;
                    end else begin
                        bub_d = bub_q - BUB_W'(1);
                    end
                end else if (fetch_valid_q && imem_ready && !stall) begin
                    pc_d = pc_q + PC_W'(4);
                end
            end
            default: begin
                state_d = S_BOOT;
                bub_d   = '0;
            end
        endcase

        fetch_valid_d = (state_d == S_RUN);
        flush_d       = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            bub_q         <= '0;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            bub_q         <= bub_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            trap_q        <= trap_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_plus4      = pc_q + PC_W'(4);
    assign fetch_valid   = fetch_valid_q;
    assign flush         = flush_q;
    assign redirect_cnt  = cnt_q;
    assign misalign_trap = trap_q;

endmodule
